perf_cnt_reader: RTL and testbench

- Read-side companion to the L1 cache performance counters.
- Gives the CPU a 32-bit, request/valid read port onto up to NUM_CNT free-running 64-bit event counters: L1D_access, L1D_miss, L1I_access, L1I_miss.
- Supports atomic low/high word reads through a shadow register, and software "clear" through a baseline snapshot. The source counters themselves are never reset except by rst.
- Sits between the cache counter blocks and the CSR/MMIO read mux.

---
 rtl/perf_cnt_reader.sv | 154 +++++++++++++++
 tb/tb_perf_cnt_reader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_cnt_reader.sv
// perf_cnt_reader: 32-bit request/valid read port onto free-running cache event counters.
// Reads are IDLE -> CALC -> RESP; a low-word read latches the upper half into shadow_hi so
// a following high-word read is atomic. clr rebases every counter through a baseline snapshot.
// Optional macro PERF_FREEZE_EN adds a freeze input that snapshots all counters coherently.
module perf_cnt_reader #(
    parameter int unsigned NUM_CNT = 4,
    parameter int unsigned CNT_W   = 64,
    parameter int unsigned IDX_W   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CNT*CNT_W-1:0] cnt_in,
    input  logic                     clr,
`ifdef PERF_FREEZE_EN
    input  logic                     freeze,
`endif
    input  logic                     rd_req,
    input  logic [IDX_W:0]           rd_addr,
    output logic                     rd_ready,
    output logic                     rd_valid,
    output logic [31:0]              rd_data,
    output logic                     rd_err
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDX_W:0]   addr_q, addr_d;
    logic [63:0]      delta_q, delta_d;
    logic [31:0]      shadow_hi_q, shadow_hi_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             rd_err_q, rd_err_d;
    logic [CNT_W-1:0] base_q [NUM_CNT];
    logic [CNT_W-1:0] base_d [NUM_CNT];
    logic [CNT_W-1:0] src [NUM_CNT];
    logic [IDX_W-1:0] idx;
    logic             idx_ok;
    logic [CNT_W-1:0] sel_src, sel_base, diff;
    logic [31:0]      resp_data;

    assign idx    = addr_q[IDX_W:1];
    assign idx_ok = 32'(idx) < NUM_CNT;

`ifdef PERF_FREEZE_EN
    logic             freeze_q, freeze_d;
    logic             frz_rise;
    logic [CNT_W-1:0] frz_q [NUM_CNT];
    logic [CNT_W-1:0] frz_d [NUM_CNT];

    // Snapshot on the first freeze cycle; the frozen view already includes that capture.
    always_comb begin
        freeze_d = freeze;
        frz_rise = freeze & ~freeze_q;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            frz_d[i] = frz_rise ? cnt_in[i*CNT_W +: CNT_W] : frz_q[i];
            src[i]   = freeze ? frz_d[i] : cnt_in[i*CNT_W +: CNT_W];
        end
    end

    // Freeze edge detector and snapshot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            freeze_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_CNT; i++) frz_q[i] <= '0;
        end else begin
            freeze_q <= freeze_d;
            for (int unsigned i = 0; i < NUM_CNT; i++) frz_q[i] <= frz_d[i];
        end
    end
`else
    // Without freeze support every read sees the live counters.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CNT; i++) src[i] = cnt_in[i*CNT_W +: CNT_W];
    end
`endif

    // Select the addressed counter and its baseline; diff wraps modulo 2^CNT_W.
    always_comb begin
        sel_src  = '0;
        sel_base = '0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            if (32'(idx) == i) begin
                sel_src  = src[i];
                sel_base = base_q[i];
            end
        end
        diff = sel_src - sel_base;
    end

    // Read FSM: latch address in IDLE, register the delta in CALC, respond in RESP.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        delta_d = delta_q;
        unique case (state_q)
            StIdle: begin
                if (rd_req) begin
                    addr_d  = rd_addr;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                delta_d = 64'(diff);
                state_d = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Response data, held outputs, shadow and baseline updates.
    always_comb begin
        rd_ready  = (state_q == StIdle);
        rd_valid  = (state_q == StResp);
        resp_data = !idx_ok ? 32'd0 : (addr_q[0] ? shadow_hi_q : delta_q[31:0]);
        rd_data   = rd_valid ? resp_data : rd_data_q;
        rd_err    = rd_valid ? !idx_ok : rd_err_q;
        rd_data_d = rd_data;
        rd_err_d  = rd_err;

        shadow_hi_d = shadow_hi_q;
        if (rd_valid && idx_ok && !addr_q[0]) shadow_hi_d = delta_q[63:32];
        // clr wins over a coincident low-word shadow update.
        if (clr) shadow_hi_d = 32'd0;

        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            base_d[i] = clr ? src[i] : base_q[i];
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            delta_q     <= '0;
            shadow_hi_q <= '0;
            rd_data_q   <= '0;
            rd_err_q    <= 1'b0;
            for (int unsigned i = 0; i < NUM_CNT; i++) base_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            delta_q     <= delta_d;
            shadow_hi_q <= shadow_hi_d;
            rd_data_q   <= rd_data_d;
            rd_err_q    <= rd_err_d;
            for (int unsigned i = 0; i < NUM_CNT; i++) base_q[i] <= base_d[i];
        end
    end

endmodule

// File: tb/tb_perf_cnt_reader.sv
// Self-checking bench for perf_cnt_reader: directed reads with literal expectations plus a
// per-cycle comparison against a timeline model of the read protocol.
module tb_perf_cnt_reader;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] cnt_in;
    logic         clr = 1'b0;
    logic         freeze = 1'b0;
    logic         rd_req = 1'b0;
    logic [3:0]   rd_addr = '0;
    logic         rd_ready, rd_valid, rd_err;
    logic [31:0]  rd_data;

    logic [63:0]  cnt [4];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always_comb begin
        cnt_in = '0;
        for (int i = 0; i < 4; i++) cnt_in[i*64 +: 64] = cnt[i];
    end

    perf_cnt_reader dut (
        .clk      (clk),
        .rst      (rst),
        .cnt_in   (cnt_in),
        .clr      (clr),
`ifdef PERF_FREEZE_EN
        .freeze   (freeze),
`endif
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_err   (rd_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- Model: cycle timeline of accepted reads ----------------
    int          cyc = 0;
    int          calc_cyc = -1, resp_cyc = -1, free_cyc = 0;
    logic [3:0]  m_addr = '0;
    logic [63:0] m_delta = '0;
    logic [63:0] m_base [4];
    logic [63:0] m_frz [4];
    logic [63:0] m_live [4];
    logic [31:0] m_shadow = '0;
    logic        m_frz_prev = 1'b0;
    logic        m_rise;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_base[i] = '0;
                m_frz[i]  = '0;
            end
            m_shadow   = '0;
            m_frz_prev = 1'b0;
            calc_cyc   = -1;
            resp_cyc   = -1;
            free_cyc   = cyc + 1;
        end else begin
            m_rise = freeze && !m_frz_prev;
            for (int i = 0; i < 4; i++)
                m_live[i] = freeze ? (m_rise ? cnt[i] : m_frz[i]) : cnt[i];
            if (cyc == calc_cyc) begin
                if (m_addr[3:1] < 3'd4) m_delta = m_live[m_addr[3:1]] - m_base[m_addr[3:1]];
                else m_delta = '0;
            end
            if (cyc == resp_cyc && m_addr[3:1] < 3'd4 && !m_addr[0]) m_shadow = m_delta[63:32];
            if (clr) begin
                for (int i = 0; i < 4; i++) m_base[i] = m_live[i];
                m_shadow = '0;
            end
            if (m_rise) for (int i = 0; i < 4; i++) m_frz[i] = cnt[i];
            m_frz_prev = freeze;
            if (cyc >= free_cyc && rd_req) begin
                m_addr   = rd_addr;
                calc_cyc = cyc + 1;
                resp_cyc = cyc + 2;
                free_cyc = cyc + 3;
            end
        end
        cyc++;
    end

    // Compare every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            check("ready", 64'(rd_ready), 64'(cyc >= free_cyc));
            check("valid", 64'(rd_valid), 64'(cyc == resp_cyc));
            if (rd_valid && cyc == resp_cyc) begin
                if (m_addr[3:1] >= 3'd4) begin
                    check("model_data", 64'(rd_data), 64'd0);
                    check("model_err", 64'(rd_err), 64'd1);
                end else begin
                    check("model_data", 64'(rd_data), 64'(m_addr[0] ? m_shadow : m_delta[31:0]));
                    check("model_err", 64'(rd_err), 64'd0);
                end
            end
        end
    end

    // ---------------- Directed stimulus ----------------
    task automatic do_read(input logic [3:0] a, input logic clr_calc,
                           output logic [31:0] d, output logic e, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!rd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        rd_req  = 1'b1;
        rd_addr = a;
        @(negedge clk);
        rd_req = 1'b0;
        clr    = clr_calc;
        lat    = 1;
        while (!rd_valid && lat < 10) begin
            @(negedge clk);
            clr = 1'b0;
            lat++;
        end
        clr = 1'b0;
        d   = rd_data;
        e   = rd_err;
    endtask

    // Latency 2 negedges after the accepting edge: third cycle counting the request cycle.
    task automatic rd_chk(input string name, input logic [3:0] a, input logic clr_calc,
                          input logic [31:0] exp_d, input logic exp_e);
        logic [31:0] d;
        logic        e;
        int          lat;
        do_read(a, clr_calc, d, e, lat);
        check({name, "_lat"}, 64'(lat), 64'd2);
        check({name, "_data"}, 64'(d), 64'(exp_d));
        check({name, "_err"}, 64'(e), 64'(exp_e));
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        int nvalid;
        for (int i = 0; i < 4; i++) cnt[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(rd_ready), 64'd1);
        check("rst_valid", 64'(rd_valid), 64'd0);
        check("rst_data", 64'(rd_data), 64'd0);
        check("rst_err", 64'(rd_err), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Low then high word of idx0
        cnt[0] = 64'h0000_0005_0000_0010;
        rd_chk("idx0_lo", 4'b0000, 1'b0, 32'h0000_0010, 1'b0);
        rd_chk("idx0_hi", 4'b0001, 1'b0, 32'h0000_0005, 1'b0);

        // Atomic pair: counter moves between low and high reads
        cnt[1] = 64'h0000_0001_FFFF_FFFF;
        rd_chk("idx1_lo", 4'b0010, 1'b0, 32'hFFFF_FFFF, 1'b0);
        cnt[1] = 64'h0000_0002_0000_0003;
        rd_chk("idx1_hi", 4'b0011, 1'b0, 32'h0000_0001, 1'b0);

        // Clear rebases all counters and zeroes the shadow
        cnt[3] = 64'd50;
        cnt[2] = 64'd1000;
        pulse_clr();
        rd_chk("shadow_clr", 4'b0001, 1'b0, 32'h0, 1'b0);
        cnt[2] = 64'd1042;
        rd_chk("idx2_clr", 4'b0100, 1'b0, 32'd42, 1'b0);
        cnt[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        rd_chk("idx2_wrap_lo", 4'b0100, 1'b0, 32'hFFFF_FC17, 1'b0);
        rd_chk("idx2_wrap_hi", 4'b0101, 1'b0, 32'hFFFF_FFFF, 1'b0);

        // Invalid indices leave the shadow alone
        rd_chk("idx5_lo", 4'b1010, 1'b0, 32'h0, 1'b1);
        rd_chk("after_inv_hi", 4'b0001, 1'b0, 32'hFFFF_FFFF, 1'b0);
        rd_chk("idx7_hi", 4'b1111, 1'b0, 32'h0, 1'b1);

        // clr during CALC: this read uses the old baseline, the next one the new
        cnt[0] = 64'h0000_0005_0000_0110;
        rd_chk("clr_calc_old", 4'b0000, 1'b1, 32'h0000_0100, 1'b0);
        rd_chk("clr_calc_new", 4'b0000, 1'b0, 32'h0, 1'b0);

        // rd_req held high: one response per three cycles
        @(negedge clk);
        rd_req  = 1'b1;
        rd_addr = 4'b0000;
        nvalid  = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (rd_valid) nvalid++;
        end
        rd_req = 1'b0;
        check("busy_valids", 64'(nvalid), 64'd4);

        // Reset during CALC aborts the read and clears baselines
        cnt[3] = 64'd77;
        @(negedge clk);
        rd_req  = 1'b1;
        rd_addr = 4'b0110;
        @(negedge clk);
        rd_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_mid_ready", 64'(rd_ready), 64'd1);
        check("rst_mid_valid", 64'(rd_valid), 64'd0);
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        nvalid = 0;
        repeat (4) begin
            @(negedge clk);
            if (rd_valid) nvalid++;
        end
        check("rst_no_valid", 64'(nvalid), 64'd0);
        rd_chk("idx3_base0", 4'b0110, 1'b0, 32'd77, 1'b0);
        rd_chk("idx0_base0", 4'b0000, 1'b0, 32'h0000_0110, 1'b0);

`ifdef PERF_FREEZE_EN
        @(negedge clk);
        cnt[0] = 64'd100;
        cnt[1] = 64'd7;
        freeze = 1'b1;
        @(negedge clk);
        cnt[0] = 64'd130;
        cnt[1] = 64'd8;
        rd_chk("frz_idx0", 4'b0000, 1'b0, 32'd100, 1'b0);
        rd_chk("frz_idx1", 4'b0010, 1'b0, 32'd7, 1'b0);
        pulse_clr();
        rd_chk("frz_clr0", 4'b0000, 1'b0, 32'd0, 1'b0);
        rd_chk("frz_clr1", 4'b0010, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        freeze = 1'b0;
        cnt[0] = 64'd150;
        cnt[1] = 64'd9;
        rd_chk("unfrz_idx0", 4'b0000, 1'b0, 32'd50, 1'b0);
        rd_chk("unfrz_idx1", 4'b0010, 1'b0, 32'd2, 1'b0);
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
